// File: rtl/ah_packet_converter_w2n_if.sv
// Packet-side and flit-side signals of the wide-to-narrow converter.
// wlast exists only when AH_W2N_LAST_EN is defined.
interface ah_packet_converter_w2n_if #(
  parameter int WIDE_W   = 64,
  parameter int NARROW_W = 16
);
  logic [WIDE_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [NARROW_W-1:0] wdata;
  logic                wvalid;
  logic                wcredit;
`ifdef AH_W2N_LAST_EN
  logic                wlast;

  modport master (
    output rdata, rvalid, wcredit,
    input  rready, wdata, wvalid, wlast
  );

  modport slave (
    input  rdata, rvalid, wcredit,
    output rready, wdata, wvalid, wlast
  );
`else
  modport master (
    output rdata, rvalid, wcredit,
    input  rready, wdata, wvalid
  );

  modport slave (
    input  rdata, rvalid, wcredit,
    output rready, wdata, wvalid
  );
`endif
endinterface

// File: rtl/ah_packet_converter_w2n.sv
// Wide-to-narrow packet serialiser onto a credit-flow-controlled flit link, LSB lane first.
// Optional macro AH_W2N_LAST_EN adds a registered wlast marker on the final flit of a packet.
module ah_packet_converter_w2n #(
  parameter int WIDE_W   = 64,
  parameter int NARROW_W = 16,
  parameter int CREDITS  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  ah_packet_converter_w2n_if.slave  bus
);

  localparam int                LANES     = WIDE_W / NARROW_W;
  localparam int                LANE_W    = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [3:0]        CRED_MAX  = 4'(CREDITS);

  logic [WIDE_W-1:0]   buf_q;
  logic                full_q;
  logic [LANE_W-1:0]   lane_q;
  logic [3:0]          cred_cnt;
  logic [NARROW_W-1:0] wdata_p0;
  logic                vld_p0;
  logic                send;
  logic                last;
  logic                accept;

  function automatic logic [NARROW_W-1:0] lane_flit(
    input logic [WIDE_W-1:0] pkt,
    input logic [LANE_W-1:0] idx
  );
    return pkt[int'(idx)*NARROW_W +: NARROW_W];
  endfunction

  // A credit returned while the counter is already full is a protocol error; clamp it.
  function automatic logic [3:0] cred_next(
    input logic [3:0] cnt,
    input logic       dec,
    input logic       inc
  );
    logic [4:0] sum;
    sum = {1'b0, cnt} - {4'b0, dec} + {4'b0, inc};
    return (sum > {1'b0, CRED_MAX}) ? CRED_MAX : sum[3:0];
  endfunction

  // Credits arriving this cycle only become usable once registered.
  always_comb begin
    send   = full_q && (cred_cnt != 4'd0);
    last   = send && (lane_q == LAST_LANE);
    accept = bus.rvalid && bus.rready;
  end

  assign bus.rready = !full_q || last;

  // stage p0: control state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q   <= 1'b0;
      lane_q   <= '0;
      cred_cnt <= CRED_MAX;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0   <= send;
      cred_cnt <= cred_next(cred_cnt, send, bus.wcredit);
      if (send) begin
        lane_q <= last ? '0 : lane_q + LANE_W'(1);
      end
      if (accept) begin
        full_q <= 1'b1;
      end else if (last) begin
        full_q <= 1'b0;
      end
    end
  end

  // stage p0: packet buffer and outgoing flit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q    <= '0;
      wdata_p0 <= '0;
    end else begin
      if (accept) begin
        buf_q <= bus.rdata;
      end
      if (send) begin
        wdata_p0 <= lane_flit(buf_q, lane_q);
      end
    end
  end

  assign bus.wdata  = wdata_p0;
  assign bus.wvalid = vld_p0;

`ifdef AH_W2N_LAST_EN
  logic last_p0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_p0 <= 1'b0;
    end else begin
      last_p0 <= last;
    end
  end

  assign bus.wlast = last_p0;
`endif

endmodule

// File: tb/tb_ah_packet_converter_w2n.sv
// Bench for ah_packet_converter_w2n: directed vector table, corner sequences and a
// randomized run checked against a flit-queue/credit-count reference model.
module tb_ah_packet_converter_w2n;

  localparam int WIDE_W   = 64;
  localparam int NARROW_W = 16;
  localparam int CREDITS  = 4;
  localparam int LANES    = WIDE_W / NARROW_W;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  ah_packet_converter_w2n_if #(.WIDE_W(WIDE_W), .NARROW_W(NARROW_W)) bus ();

  ah_packet_converter_w2n #(
    .WIDE_W  (WIDE_W),
    .NARROW_W(NARROW_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the flits still owed for the buffered packet, plus the credit count.
  logic [NARROW_W-1:0] mq[$];
  int                  mcred;
  logic                m_vld;
  logic [NARROW_W-1:0] m_dat;
  logic                m_lst;
  logic                m_acc;
  int                  obs_run;
  int                  obs_max_run;
  int                  obs_rdy_low;

  task automatic model_reset();
    mq.delete();
    mcred       = CREDITS;
    m_vld       = 1'b0;
    m_dat       = '0;
    m_lst       = 1'b0;
    m_acc       = 1'b0;
    obs_run     = 0;
    obs_max_run = 0;
    obs_rdy_low = 0;
  endtask

  task automatic do_reset();
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.wcredit = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_rready", bus.rready, 1);
    chk("rst_cred", dut.cred_cnt, CREDITS);
`ifdef AH_W2N_LAST_EN
    chk("rst_wlast", bus.wlast, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic cyc(input logic rv, input logic [WIDE_W-1:0] rd, input logic wc);
    bit send, last, rdy;
    bus.rvalid  = rv;
    bus.rdata   = rd;
    bus.wcredit = wc;
    @(negedge clk);
    send = (mq.size() != 0) && (mcred != 0);
    last = send && (mq.size() == 1);
    rdy  = (mq.size() == 0) || last;
    chk("rready", bus.rready, rdy);
    chk("wvalid", bus.wvalid, m_vld);
    chk("wdata", bus.wdata, m_dat);
    chk("cred", dut.cred_cnt, mcred);
`ifdef AH_W2N_LAST_EN
    chk("wlast", bus.wlast, m_lst);
`endif
    if (bus.wvalid) begin
      obs_run++;
      if (obs_run > obs_max_run) obs_max_run = obs_run;
    end else begin
      obs_run = 0;
    end
    if (!bus.rready) obs_rdy_low++;
    m_vld = send;
    m_lst = last;
    if (send) m_dat = mq.pop_front();
    m_acc = rv && rdy;
    if (m_acc) begin
      for (int i = 0; i < LANES; i++) mq.push_back(rd[i*NARROW_W +: NARROW_W]);
    end
    mcred = mcred - int'(send) + int'(wc);
    if (mcred > CREDITS) mcred = CREDITS;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic                rv;
    logic [WIDE_W-1:0]   rd;
    logic                wc;
    logic                rdy;
    logic                vld;
    logic [NARROW_W-1:0] dat;
    logic                lst;
    logic [3:0]          cred;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic rv, input logic [WIDE_W-1:0] rd, input logic wc,
                              input logic rdy, input logic vld, input logic [NARROW_W-1:0] dat,
                              input logic lst, input logic [3:0] cred);
    vec_t v;
    v.rv = rv; v.rd = rd; v.wc = wc;
    v.rdy = rdy; v.vld = vld; v.dat = dat; v.lst = lst; v.cred = cred;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDE_W-1:0] pk[2];
    int p;

    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.wcredit = 1'b0;
    model_reset();

    // Single packet, then credit exhaustion and a single returned credit.
    tbl[0]  = mk(1, 64'h4444_3333_2222_1111, 0, 1, 0, 16'h0000, 0, 4);
    tbl[1]  = mk(0, 64'h0,                   0, 0, 0, 16'h0000, 0, 4);
    tbl[2]  = mk(0, 64'h0,                   0, 0, 1, 16'h1111, 0, 3);
    tbl[3]  = mk(0, 64'h0,                   0, 0, 1, 16'h2222, 0, 2);
    tbl[4]  = mk(0, 64'h0,                   0, 1, 1, 16'h3333, 0, 1);
    tbl[5]  = mk(0, 64'h0,                   0, 1, 1, 16'h4444, 1, 0);
    tbl[6]  = mk(1, 64'h8888_7777_6666_5555, 0, 1, 0, 16'h4444, 0, 0);
    tbl[7]  = mk(0, 64'h0,                   0, 0, 0, 16'h4444, 0, 0);
    tbl[8]  = mk(0, 64'h0,                   1, 0, 0, 16'h4444, 0, 0);
    tbl[9]  = mk(0, 64'h0,                   0, 0, 0, 16'h4444, 0, 1);
    tbl[10] = mk(0, 64'h0,                   0, 0, 1, 16'h5555, 0, 0);
    tbl[11] = mk(0, 64'h0,                   0, 0, 0, 16'h5555, 0, 0);
    tbl[12] = mk(0, 64'h0,                   0, 0, 0, 16'h5555, 0, 0);

    #2;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      bus.rvalid  = tbl[i].rv;
      bus.rdata   = tbl[i].rd;
      bus.wcredit = tbl[i].wc;
      @(negedge clk);
      chk($sformatf("tbl%0d_rready", i), bus.rready, tbl[i].rdy);
      chk($sformatf("tbl%0d_wvalid", i), bus.wvalid, tbl[i].vld);
      chk($sformatf("tbl%0d_wdata", i), bus.wdata, tbl[i].dat);
      chk($sformatf("tbl%0d_cred", i), dut.cred_cnt, tbl[i].cred);
`ifdef AH_W2N_LAST_EN
      chk($sformatf("tbl%0d_wlast", i), bus.wlast, tbl[i].lst);
`endif
      @(posedge clk);
      #1;
    end

    // Back-to-back packets with a credit every cycle: one unbroken run of 8 flits.
    do_reset();
    pk[0] = 64'hA004_A003_A002_A001;
    pk[1] = 64'hB004_B003_B002_B001;
    p = 0;
    for (int c = 0; c < 14; c++) begin
      if (p < 2) begin
        cyc(1'b1, pk[p], 1'b1);
        if (m_acc) p++;
      end else begin
        cyc(1'b0, '0, 1'b1);
      end
    end
    chk("b2b_accepted", p, 2);
    chk("b2b_run", obs_max_run, 8);
    chk("b2b_rready_low", obs_rdy_low, 6);

    // Credit returned alongside the 4th flit, then a surplus credit at the full count.
    do_reset();
    cyc(1'b1, 64'hC004_C003_C002_C001, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 64'hD004_D003_D002_D001, 1'b1);
    chk("coincide_accept", m_acc, 1);
    chk("coincide_cred", dut.cred_cnt, 1);
    cyc(1'b0, '0, 1'b0);
    chk("coincide_next_flit", bus.wvalid, 1);
    for (int c = 0; c < 8; c++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("cred_saturate", dut.cred_cnt, CREDITS);

    // Asynchronous reset after two flits of a packet, then a clean packet.
    do_reset();
    cyc(1'b1, 64'hE004_E003_E002_E001, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("midpkt_flits_out", bus.wvalid, 1);
    do_reset();
    cyc(1'b1, 64'hF004_F003_F002_F001, 1'b0);
    for (int c = 0; c < 7; c++) cyc(1'b0, '0, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
    end
    for (int c = 0; c < 16; c++) cyc(1'b0, '0, 1'b1);
    chk("rand_drained", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
